// File: rtl/osc_pkg.sv
// -----------------------------------------------------------------------------
// osc_pkg
// Shared types for the poly_wave_oscillator bank.
//   wave_mode_t : per-voice waveform selector (encoding matches cfg_mode_in)
//   osc_state_t : sweep sequencer state
//   voice_w()   : voice index width, never less than 1 bit
// -----------------------------------------------------------------------------
package osc_pkg;

  typedef enum logic [1:0] {
    WAVE_TRI    = 2'd0,
    WAVE_SAW    = 2'd1,
    WAVE_PULSE  = 2'd2,
    WAVE_SILENT = 2'd3
  } wave_mode_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } osc_state_t;

  function automatic int voice_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wave_shaper.sv
// -----------------------------------------------------------------------------
// wave_shaper
// Purely combinational phase-to-amplitude converter. With H = 2^(PHASE_W-1):
//   triangle : rising half 2p - H, falling half (H-1) - 2(p-H)
//   saw      : p - H (MSB inverted)
//   pulse    : H-1 while p < pw, else -H (pw = 0 gives constant -H)
//   silent   : 0
// Ports:
//   i_phase  [PHASE_W] current phase of the voice
//   i_mode   [2]       waveform selector
//   i_pw     [PHASE_W] pulse-width threshold
//   o_sample [PHASE_W] signed full-width sample
// -----------------------------------------------------------------------------
module wave_shaper
  import osc_pkg::*;
#(
  parameter int PHASE_W = 32
) (
  input  logic [PHASE_W-1:0]        i_phase,
  input  wave_mode_t                i_mode,
  input  logic [PHASE_W-1:0]        i_pw,
  output logic signed [PHASE_W-1:0] o_sample
);

  localparam logic [PHASE_W-1:0] HALF = {1'b1, {(PHASE_W-1){1'b0}}};

  // Doubled phase with the MSB dropped: the position within either
  // triangle half, scaled to the full range.
  logic [PHASE_W-1:0] w_dbl;
  assign w_dbl = {i_phase[PHASE_W-2:0], 1'b0};

  always_comb begin
    o_sample = '0;
    case (i_mode)
      WAVE_TRI:    o_sample = i_phase[PHASE_W-1] ? ((HALF - 1'b1) - w_dbl)
                                                 : (w_dbl - HALF);
      WAVE_SAW:    o_sample = {~i_phase[PHASE_W-1], i_phase[PHASE_W-2:0]};
      WAVE_PULSE:  o_sample = (i_phase < i_pw) ? (HALF - 1'b1) : HALF;
      WAVE_SILENT: o_sample = '0;
      default:     o_sample = '0;
    endcase
  end

endmodule

// File: rtl/poly_wave_oscillator.sv
// -----------------------------------------------------------------------------
// poly_wave_oscillator
// Time-multiplexed bank of NUM_VOICES phase accumulators. A step_in tick
// starts a sweep that emits one tagged sample per voice on consecutive cycles
// (voice 0 first, the cycle after the tick).
//
// Build option: define POLY_OSC_WRAP_FLAG_EN to add amp_wrap_out, a flag that
// marks samples whose phase update carried out of PHASE_W bits.
//
// Ports:
//   clk_in, rst_in      clock, synchronous active-high reset
//   step_in             sample tick, ignored (and flagged) while busy
//   cfg_*_in            per-voice config write (incr, mode, pw, phase reset)
//   amp_out             signed sample, top OUT_W bits of the waveform
//   amp_voice_out       voice index of amp_out
//   amp_valid_out       amp_out/amp_voice_out valid
//   busy_out            sweep in progress
//   step_missed_out     one-cycle pulse for a step_in that arrived while busy
//   amp_wrap_out        (optional) phase carry for this sample
//
// Output stream: amp_valid_out is a pure one-cycle qualifier with no ready;
// the consumer must take every sample in the cycle it is valid.
// -----------------------------------------------------------------------------
module poly_wave_oscillator
  import osc_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int PHASE_W    = 32,
  parameter int OUT_W      = 24,
  localparam int VOICE_W   = voice_w(NUM_VOICES)
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               step_in,
  input  logic               cfg_we_in,
  input  logic [VOICE_W-1:0] cfg_voice_in,
  input  logic [PHASE_W-1:0] cfg_incr_in,
  input  logic [1:0]         cfg_mode_in,
  input  logic [PHASE_W-1:0] cfg_pw_in,
  input  logic               cfg_phase_rst_in,
  output logic [OUT_W-1:0]   amp_out,
  output logic [VOICE_W-1:0] amp_voice_out,
  output logic               amp_valid_out,
  output logic               busy_out,
  output logic               step_missed_out
`ifdef POLY_OSC_WRAP_FLAG_EN
  ,
  output logic               amp_wrap_out
`endif
);

  // Per-voice state
  logic [PHASE_W-1:0] r_phase [NUM_VOICES];
  logic [PHASE_W-1:0] r_incr  [NUM_VOICES];
  logic [PHASE_W-1:0] r_pw    [NUM_VOICES];
  wave_mode_t         r_mode  [NUM_VOICES];

  // Sequencer. RUN means a sample is on amp_out this cycle and r_voice is
  // its voice; the voice processed at the next edge is r_voice + 1.
  osc_state_t         r_state;
  logic [VOICE_W-1:0] r_voice;
  logic [OUT_W-1:0]   r_amp;
  logic               r_missed;

  logic               w_last;
  logic               w_proc;
  logic [VOICE_W-1:0] w_v;
  logic               w_cfg_ok;
  logic               w_rst_hit;
  logic [PHASE_W-1:0] w_next;
  logic signed [PHASE_W-1:0] w_sample;

  assign w_last = (r_voice == VOICE_W'(NUM_VOICES - 1));
  // Accepting a tick processes voice 0 at the same edge, so the first
  // sample is registered one cycle after step_in.
  assign w_proc = (r_state == IDLE) ? step_in : !w_last;
  assign w_v    = (r_state == IDLE) ? '0 : (r_voice + 1'b1);

  // Guards writes to non-existent voices when NUM_VOICES is not a power of 2.
  assign w_cfg_ok  = ({1'b0, cfg_voice_in} < (VOICE_W + 1)'(NUM_VOICES));
  assign w_rst_hit = cfg_we_in && w_cfg_ok && cfg_phase_rst_in && (cfg_voice_in == w_v);
  assign w_next    = r_phase[w_v] + r_incr[w_v];

  wave_shaper #(
    .PHASE_W (PHASE_W)
  ) u_wave_shaper (
    .i_phase  (r_phase[w_v]),
    .i_mode   (r_mode[w_v]),
    .i_pw     (r_pw[w_v]),
    .o_sample (w_sample)
  );

  generate
    if (OUT_W < PHASE_W) begin : g_trunc
      logic w_unused_lsb;
      assign w_unused_lsb = ^w_sample[PHASE_W-OUT_W-1:0];
    end
  endgenerate

`ifdef POLY_OSC_WRAP_FLAG_EN
  logic r_wrap;
  // Unsigned add overflowed exactly when the sum is below an operand.
  logic w_carry;
  assign w_carry = (w_next < r_phase[w_v]);
`endif

  // Sequencer and registered outputs
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state  <= IDLE;
      r_voice  <= '0;
      r_amp    <= '0;
      r_missed <= 1'b0;
`ifdef POLY_OSC_WRAP_FLAG_EN
      r_wrap   <= 1'b0;
`endif
    end else begin
      r_missed <= (r_state == RUN) && step_in;
      if (w_proc) begin
        r_state <= RUN;
        r_voice <= w_v;
        r_amp   <= w_sample[PHASE_W-1 -: OUT_W];
`ifdef POLY_OSC_WRAP_FLAG_EN
        r_wrap  <= w_carry && !w_rst_hit;
`endif
      end else begin
        r_state <= IDLE;
      end
    end
  end

  // Phase accumulation and config storage. A phase reset written in the
  // same cycle is assigned last so it overrides the accumulation.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_phase[i] <= '0;
        r_incr[i]  <= '0;
        r_pw[i]    <= '0;
        r_mode[i]  <= WAVE_SILENT;
      end
    end else begin
      if (w_proc) r_phase[w_v] <= w_next;
      if (cfg_we_in && w_cfg_ok) begin
        r_incr[cfg_voice_in] <= cfg_incr_in;
        r_pw[cfg_voice_in]   <= cfg_pw_in;
        r_mode[cfg_voice_in] <= wave_mode_t'(cfg_mode_in);
        if (cfg_phase_rst_in) r_phase[cfg_voice_in] <= '0;
      end
    end
  end

  assign amp_out         = r_amp;
  assign amp_voice_out   = r_voice;
  assign amp_valid_out   = (r_state == RUN);
  assign busy_out        = (r_state == RUN);
  assign step_missed_out = r_missed;
`ifdef POLY_OSC_WRAP_FLAG_EN
  assign amp_wrap_out    = r_wrap;
`endif

  // w_rst_hit only feeds the wrap flag; keep it referenced in the base build.
`ifndef POLY_OSC_WRAP_FLAG_EN
  logic w_unused_rst_hit;
  assign w_unused_rst_hit = w_rst_hit;
`endif

endmodule

// File: tb/tb_poly_wave_oscillator.sv
// -----------------------------------------------------------------------------
// tb_poly_wave_oscillator
// Self-checking bench for poly_wave_oscillator (NUM_VOICES=8, PHASE_W=32,
// OUT_W=24). Every sample is checked against a queue filled from a behavioural
// model; table entries and corner sequences add hand-derived constants.
// -----------------------------------------------------------------------------
module tb_poly_wave_oscillator;

  localparam int NV = 8;
  localparam int PW = 32;
  localparam int OW = 24;
  localparam int VW = 3;
  localparam int EW = 1 + VW + OW;

  // ---------------- clock / reset / DUT ----------------
  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          step_in;
  logic          cfg_we_in;
  logic [VW-1:0] cfg_voice_in;
  logic [PW-1:0] cfg_incr_in;
  logic [1:0]    cfg_mode_in;
  logic [PW-1:0] cfg_pw_in;
  logic          cfg_phase_rst_in;
  logic [OW-1:0] amp_out;
  logic [VW-1:0] amp_voice_out;
  logic          amp_valid_out;
  logic          busy_out;
  logic          step_missed_out;
  logic          wrap_act;

  always #5 clk_in = ~clk_in;

  poly_wave_oscillator #(
    .NUM_VOICES (NV),
    .PHASE_W    (PW),
    .OUT_W      (OW)
  ) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .step_in          (step_in),
    .cfg_we_in        (cfg_we_in),
    .cfg_voice_in     (cfg_voice_in),
    .cfg_incr_in      (cfg_incr_in),
    .cfg_mode_in      (cfg_mode_in),
    .cfg_pw_in        (cfg_pw_in),
    .cfg_phase_rst_in (cfg_phase_rst_in),
    .amp_out          (amp_out),
    .amp_voice_out    (amp_voice_out),
    .amp_valid_out    (amp_valid_out),
    .busy_out         (busy_out),
    .step_missed_out  (step_missed_out)
`ifdef POLY_OSC_WRAP_FLAG_EN
    ,
    .amp_wrap_out     (wrap_act)
`endif
  );

`ifndef POLY_OSC_WRAP_FLAG_EN
  assign wrap_act = 1'b0;
`endif

  // ---------------- counters ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int samp_cnt = 0;
  int busy_cnt = 0;
  int missed_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [PW-1:0] m_phase [NV];
  logic [PW-1:0] m_incr  [NV];
  logic [PW-1:0] m_pw    [NV];
  logic [1:0]    m_mode  [NV];

  function automatic logic [OW-1:0] m_wave(input logic [PW-1:0] p, input logic [1:0] mode,
                                           input logic [PW-1:0] pw);
    logic [PW-1:0] h;
    logic [PW-1:0] r;
    h = '0;
    h[PW-1] = 1'b1;
    case (mode)
      2'd0:    r = (p < h) ? (p * 2) - h : (h - 1) - ((p - h) * 2);
      2'd1:    r = p - h;
      2'd2:    r = (p < pw) ? (h - 1) : h;
      default: r = '0;
    endcase
    return r[PW-1 -: OW];
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_phase[v] = '0;
      m_incr[v]  = '0;
      m_pw[v]    = '0;
      m_mode[v]  = 2'd3;
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [OW:0]   cap_q[$];
  int            cap_voice = -1;
  logic [OW-1:0] last_amp [NV];

  task automatic push_sweep();
    logic [PW:0]   sum;
    logic          wrap;
    logic [OW-1:0] amp;
    for (int v = 0; v < NV; v++) begin
      amp  = m_wave(m_phase[v], m_mode[v], m_pw[v]);
      sum  = {1'b0, m_phase[v]} + {1'b0, m_incr[v]};
`ifdef POLY_OSC_WRAP_FLAG_EN
      wrap = sum[PW];
`else
      wrap = 1'b0;
`endif
      exp_q.push_back({wrap, VW'(v), amp});
      m_phase[v] = sum[PW-1:0];
    end
  endtask

  always @(negedge clk_in) begin
    if (busy_out === 1'b1) busy_cnt++;
    if (step_missed_out === 1'b1) missed_cnt++;
    if (amp_valid_out === 1'b1) begin
      samp_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_sample", 64'(amp_voice_out), 64'hFFFF);
      end else begin
        check("sample", 64'({wrap_act, amp_voice_out, amp_out}), 64'(exp_q.pop_front()));
      end
      last_amp[amp_voice_out] = amp_out;
      if (int'(amp_voice_out) == cap_voice) cap_q.push_back({wrap_act, amp_out});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_cfg(input int v, input logic [PW-1:0] incr, input logic [1:0] mode,
                        input logic [PW-1:0] pw, input logic prst);
    cfg_we_in        = 1'b1;
    cfg_voice_in     = VW'(v);
    cfg_incr_in      = incr;
    cfg_mode_in      = mode;
    cfg_pw_in        = pw;
    cfg_phase_rst_in = prst;
    @(posedge clk_in); #1;
    cfg_we_in        = 1'b0;
    cfg_phase_rst_in = 1'b0;
    m_incr[v] = incr;
    m_mode[v] = mode;
    m_pw[v]   = pw;
    if (prst) m_phase[v] = '0;
  endtask

  task automatic wait_drain();
    int i;
    for (i = 0; i < NV + 6; i++) begin
      if (exp_q.size() == 0 && busy_out === 1'b0) break;
      @(posedge clk_in); #1;
    end
    check("sweep_drain", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic do_step();
    push_sweep();
    step_in = 1'b1;
    @(posedge clk_in); #1;
    step_in = 1'b0;
    wait_drain();
  endtask

  task automatic next_cycle();
    @(posedge clk_in); #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int            voice;
    logic [1:0]    mode;
    logic [PW-1:0] incr;
    logic [PW-1:0] pw;
    logic [OW-1:0] e0, e1, e2, e3;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int s0;
    // Triangle falling half at p=0xC0000000 is (H-1)-H = -1 -> 0xFFFFFF.
    tbl[0] = '{voice: 2, mode: 2'd0, incr: 32'h4000_0000, pw: 32'h0,
               e0: 24'h800000, e1: 24'h000000, e2: 24'h7FFFFF, e3: 24'hFFFFFF};
    tbl[1] = '{voice: 5, mode: 2'd2, incr: 32'h4000_0000, pw: 32'h8000_0000,
               e0: 24'h7FFFFF, e1: 24'h7FFFFF, e2: 24'h800000, e3: 24'h800000};
    tbl[2] = '{voice: 1, mode: 2'd1, incr: 32'h4000_0000, pw: 32'h0,
               e0: 24'h800000, e1: 24'hC00000, e2: 24'h000000, e3: 24'h400000};
    tbl[3] = '{voice: 7, mode: 2'd2, incr: 32'h4000_0000, pw: 32'h0,
               e0: 24'h800000, e1: 24'h800000, e2: 24'h800000, e3: 24'h800000};

    rst_in = 1'b1; step_in = 1'b0; cfg_we_in = 1'b0; cfg_voice_in = '0;
    cfg_incr_in = '0; cfg_mode_in = 2'd3; cfg_pw_in = '0; cfg_phase_rst_in = 1'b0;
    for (int v = 0; v < NV; v++) last_amp[v] = '1;
    model_reset();

    // Reset values
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check("rst_amp", 64'(amp_out), 64'd0);
    check("rst_voice", 64'(amp_voice_out), 64'd0);
    check("rst_valid", 64'(amp_valid_out), 64'd0);
    check("rst_busy", 64'(busy_out), 64'd0);
    check("rst_missed", 64'(step_missed_out), 64'd0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    next_cycle();

    // Default sweep: eight silent samples, busy exactly eight cycles
    busy_cnt = 0; s0 = samp_cnt;
    do_step();
    check("default_busy_cycles", 64'(busy_cnt), 64'd8);
    check("default_sample_count", 64'(samp_cnt - s0), 64'd8);

    // Table-driven waveforms; a fifth step shows the phase wrapped back to 0
    for (int k = 0; k < 4; k++) begin
      cap_q.delete();
      cap_voice = tbl[k].voice;
      do_cfg(tbl[k].voice, tbl[k].incr, tbl[k].mode, tbl[k].pw, 1'b1);
      repeat (5) do_step();
      check("tbl_cap_count", 64'(cap_q.size()), 64'd5);
      if (cap_q.size() == 5) begin
        check("tbl_s0", 64'(cap_q[0][OW-1:0]), 64'(tbl[k].e0));
        check("tbl_s1", 64'(cap_q[1][OW-1:0]), 64'(tbl[k].e1));
        check("tbl_s2", 64'(cap_q[2][OW-1:0]), 64'(tbl[k].e2));
        check("tbl_s3", 64'(cap_q[3][OW-1:0]), 64'(tbl[k].e3));
        check("tbl_phase_back", 64'(cap_q[4][OW-1:0]), 64'(tbl[k].e0));
      end
    end
    cap_voice = -1;

    // Missed steps: one at t+3, one in the last-sample cycle t+8; t+9 accepted
    missed_cnt = 0; s0 = samp_cnt;
    push_sweep();
    step_in = 1'b1; next_cycle(); step_in = 1'b0;   // t+1
    next_cycle(); next_cycle();                     // t+3
    step_in = 1'b1; next_cycle(); step_in = 1'b0;   // t+4
    @(negedge clk_in);
    check("missed_pulse", 64'(step_missed_out), 64'd1);
    next_cycle();                                   // t+5
    @(negedge clk_in);
    check("missed_one_cycle", 64'(step_missed_out), 64'd0);
    next_cycle(); next_cycle(); next_cycle();       // t+8
    check("busy_last_sample", 64'(busy_out), 64'd1);
    step_in = 1'b1; next_cycle();                   // t+9, still high
    push_sweep();
    @(negedge clk_in);
    check("missed_last_cycle", 64'(step_missed_out), 64'd1);
    check("idle_at_t9", 64'(busy_out), 64'd0);
    next_cycle(); step_in = 1'b0;                   // t+10
    wait_drain();
    check("missed_count", 64'(missed_cnt), 64'd2);
    check("missed_no_extra", 64'(samp_cnt - s0), 64'd16);

    // Config write with phase reset hitting voice 3 while it is processed
    do_cfg(3, 32'h1000_0000, 2'd1, 32'h0, 1'b1);
    do_step(); do_step();                           // phase now 0x20000000
    push_sweep();
    step_in = 1'b1; next_cycle(); step_in = 1'b0;   // t+1
    next_cycle(); next_cycle();                     // t+3
    cfg_we_in = 1'b1; cfg_voice_in = 3'd3; cfg_incr_in = 32'h1000_0000;
    cfg_mode_in = 2'd0; cfg_pw_in = '0; cfg_phase_rst_in = 1'b1;
    next_cycle();
    cfg_we_in = 1'b0; cfg_phase_rst_in = 1'b0;
    m_mode[3] = 2'd0; m_phase[3] = '0;
    wait_drain();
    check("prst_old_sample", 64'(last_amp[3]), 64'hA00000);
    do_step();
    check("prst_zero_phase", 64'(last_amp[3]), 64'h800000);

`ifdef POLY_OSC_WRAP_FLAG_EN
    // Wrap flag: incr of half a cycle carries on every second sample
    cap_q.delete(); cap_voice = 6;
    do_cfg(6, 32'h8000_0000, 2'd1, 32'h0, 1'b1);
    repeat (4) do_step();
    check("wrap_count", 64'(cap_q.size()), 64'd4);
    if (cap_q.size() == 4) begin
      check("wrap_0", 64'(cap_q[0][OW]), 64'd0);
      check("wrap_1", 64'(cap_q[1][OW]), 64'd1);
      check("wrap_2", 64'(cap_q[2][OW]), 64'd0);
      check("wrap_3", 64'(cap_q[3][OW]), 64'd1);
    end
    cap_voice = -1;
`endif

    // Reset with voice 4 in flight
    push_sweep();
    step_in = 1'b1; next_cycle(); step_in = 1'b0;   // t+1
    next_cycle(); next_cycle(); next_cycle();       // t+4
    rst_in = 1'b1;
    next_cycle();                                   // t+5
    rst_in = 1'b0;
    @(negedge clk_in);
    check("midrst_valid", 64'(amp_valid_out), 64'd0);
    check("midrst_busy", 64'(busy_out), 64'd0);
    check("midrst_amp", 64'(amp_out), 64'd0);
    check("midrst_voice", 64'(amp_voice_out), 64'd0);
    exp_q.delete();
    model_reset();
    next_cycle();
    s0 = samp_cnt;
    do_step();
    check("postrst_count", 64'(samp_cnt - s0), 64'd8);
    check("postrst_v2_silent", 64'(last_amp[2]), 64'd0);
    check("postrst_v5_silent", 64'(last_amp[5]), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
